// File: rtl/fetch_predict_unit.sv
// rtl/fetch_predict_unit.sv - fetch address generator, fetch queue and optional bimodal direction predictor
// Define FETCH_BHT_EN to build the 2-bit saturating-counter branch history table.
module fetch_predict_unit #(
   parameter int          BHT_IDX_W = 6,
   parameter int          FQ_DEPTH  = 4,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [31:0] pc_from_rob,
   input  logic        valid_from_rob,
   input  logic [31:0] pc_from_decoder,
   input  logic        valid_from_decoder,
   input  logic [31:0] pc_of_branch,
   input  logic        branch_taken,
   input  logic        branch_record_valid,
   output logic [31:0] req_pc,
   output logic        req_valid,
   input  logic [31:0] cache_inst,
   input  logic        cache_compressed,
   input  logic        cache_valid,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        compressed_out,
   output logic        pred_taken_out,
   output logic        valid_out,
   input  logic        ready_in
);
   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0] inst_mem [FQ_DEPTH];
   logic [31:0] pc_mem   [FQ_DEPTH];
   logic        comp_mem [FQ_DEPTH];
   logic        pred_mem [FQ_DEPTH];

   logic        redirect, full, enq, deq, pred_bit;
   logic [31:0] redirect_pc;
   logic        unused_in;

   assign redirect    = valid_from_rob | valid_from_decoder;
   assign redirect_pc = valid_from_rob ? pc_from_rob : pc_from_decoder;
   assign full        = (count_q == CW'(FQ_DEPTH));

   assign req_pc    = fetch_pc_q;
   assign req_valid = !full && !redirect;
   assign valid_out = (count_q != '0);
   assign enq       = req_valid && cache_valid;
   // A redirect flushes the queue, so nothing is handed to decode in that cycle.
   assign deq       = valid_out && ready_in && !redirect;

   assign inst_out       = inst_mem[rd_ptr_q];
   assign pc_out         = pc_mem[rd_ptr_q];
   assign compressed_out = comp_mem[rd_ptr_q];
   assign pred_taken_out = pred_mem[rd_ptr_q];

   assign unused_in = ^{pc_of_branch, branch_taken, branch_record_valid};

`ifdef FETCH_BHT_EN
   logic [1:0]           bht_q [2**BHT_IDX_W];
   logic [BHT_IDX_W-1:0] upd_idx;

   assign upd_idx  = pc_of_branch[BHT_IDX_W:1];
   assign pred_bit = bht_q[fetch_pc_q[BHT_IDX_W:1]][1];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < 2**BHT_IDX_W; i++) bht_q[i] <= 2'b01;
      end else if (branch_record_valid) begin
         if (branch_taken && bht_q[upd_idx] != 2'b11)
            bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
         else if (!branch_taken && bht_q[upd_idx] != 2'b00)
            bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
      end
   end
`else
   assign pred_bit = 1'b0;
`endif

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (enq) begin
            fetch_pc_d = fetch_pc_q + (cache_compressed ? 32'd2 : 32'd4);
            wr_ptr_d   = wr_ptr_q + 1'b1;
         end
         if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
         if (enq && !deq)      count_d = count_q + 1'b1;
         else if (!enq && deq) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entry payload needs no reset; valid_out qualifies it.
   always_ff @(posedge clk_in) begin
      if (enq) begin
         inst_mem[wr_ptr_q] <= cache_inst;
         pc_mem[wr_ptr_q]   <= fetch_pc_q;
         comp_mem[wr_ptr_q] <= cache_compressed;
         pred_mem[wr_ptr_q] <= pred_bit;
      end
   end
endmodule

// File: tb/tb_fetch_predict_unit.sv
// tb/tb_fetch_predict_unit.sv - scoreboard bench for fetch_predict_unit (honours FETCH_BHT_EN)
module tb_fetch_predict_unit;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        comp;
      logic        pred;
   } ent_t;

`ifdef FETCH_BHT_EN
   localparam logic BHT_ON = 1'b1;
`else
   localparam logic BHT_ON = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [31:0] pc_from_rob = '0, pc_from_decoder = '0, pc_of_branch = '0;
   logic        valid_from_rob = 1'b0, valid_from_decoder = 1'b0;
   logic        branch_taken = 1'b0, branch_record_valid = 1'b0;
   logic [31:0] req_pc, cache_inst = '0, inst_out, pc_out;
   logic        req_valid, cache_compressed = 1'b0, cache_valid = 1'b0;
   logic        compressed_out, pred_taken_out, valid_out, ready_in = 1'b0;

   int          checks = 0, passes = 0;
   ent_t        sb[$];
   logic [31:0] mpc;
   int          mcount;
   logic [1:0]  mbht [64];

   fetch_predict_unit dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .pc_from_rob(pc_from_rob), .valid_from_rob(valid_from_rob),
      .pc_from_decoder(pc_from_decoder), .valid_from_decoder(valid_from_decoder),
      .pc_of_branch(pc_of_branch), .branch_taken(branch_taken),
      .branch_record_valid(branch_record_valid),
      .req_pc(req_pc), .req_valid(req_valid),
      .cache_inst(cache_inst), .cache_compressed(cache_compressed), .cache_valid(cache_valid),
      .inst_out(inst_out), .pc_out(pc_out), .compressed_out(compressed_out),
      .pred_taken_out(pred_taken_out), .valid_out(valid_out), .ready_in(ready_in)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // Model of one clock edge, evaluated on the falling edge with inputs stable.
   task automatic cycle();
      logic redir, rv, enq, deq, pred;
      @(negedge clk_in);
      redir = valid_from_rob || valid_from_decoder;
      rv    = (mcount != 4) && !redir;
      chk("req_pc", req_pc, mpc);
      chk("req_valid", {31'b0, req_valid}, {31'b0, rv});
      chk("valid_out", {31'b0, valid_out}, {31'b0, mcount != 0});
      enq  = rv && cache_valid;
      deq  = (mcount != 0) && ready_in && !redir;
      pred = BHT_ON & mbht[mpc[6:1]][1];
      if (branch_record_valid) begin
         if (branch_taken && mbht[pc_of_branch[6:1]] != 2'd3)
            mbht[pc_of_branch[6:1]] = mbht[pc_of_branch[6:1]] + 2'd1;
         else if (!branch_taken && mbht[pc_of_branch[6:1]] != 2'd0)
            mbht[pc_of_branch[6:1]] = mbht[pc_of_branch[6:1]] - 2'd1;
      end
      if (redir) begin
         mpc    = valid_from_rob ? pc_from_rob : pc_from_decoder;
         mcount = 0;
         sb.delete();
      end else begin
         if (enq) begin
            sb.push_back('{inst: cache_inst, pc: mpc, comp: cache_compressed, pred: pred});
            mpc = mpc + (cache_compressed ? 32'd2 : 32'd4);
         end
         mcount = mcount + (enq ? 1 : 0) - (deq ? 1 : 0);
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic fetch_at_40(input logic exp_pred, input logic upd, input logic upd_taken);
      ready_in = 1'b0;
      valid_from_decoder = 1'b1; pc_from_decoder = 32'h40;
      cycle();
      valid_from_decoder = 1'b0;
      cache_valid = 1'b1; cache_compressed = 1'b0; cache_inst = 32'h00000063;
      branch_record_valid = upd; branch_taken = upd_taken; pc_of_branch = 32'h40;
      cycle();
      cache_valid = 1'b0; branch_record_valid = 1'b0;
      chk("bht_pred_40", {31'b0, pred_taken_out}, {31'b0, exp_pred & BHT_ON});
      chk("bht_pc_40", pc_out, 32'h40);
      ready_in = 1'b1;
      repeat (2) cycle();
      ready_in = 1'b0;
   endtask

   task automatic branch_updates(input int n, input logic taken);
      branch_record_valid = 1'b1; branch_taken = taken; pc_of_branch = 32'h40;
      repeat (n) cycle();
      branch_record_valid = 1'b0;
   endtask

   always @(negedge clk_in) begin
      ent_t e;
      if (rst_n_in && valid_out && ready_in && !valid_from_rob && !valid_from_decoder) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL head_unexpected: got pc %h with empty scoreboard", pc_out);
         end else begin
            e = sb.pop_front();
            if ({inst_out, pc_out, compressed_out, pred_taken_out} === e) passes++;
            else $display("FAIL head_entry: got inst %h pc %h c %b p %b required inst %h pc %h c %b p %b",
                          inst_out, pc_out, compressed_out, pred_taken_out, e.inst, e.pc, e.comp, e.pred);
         end
      end
   end

   initial begin
      mpc = 32'h0; mcount = 0;
      for (int i = 0; i < 64; i++) mbht[i] = 2'b01;
      valid_from_rob = 1'b1; pc_from_rob = 32'hdead0000;
      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_req_pc", req_pc, 32'h0);
      chk("reset_valid_out", {31'b0, valid_out}, 32'h0);
      valid_from_rob = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;
      chk("post_reset_req_pc", req_pc, 32'h0);

      // fill until full with ready low
      cache_valid = 1'b1; cache_inst = 32'h00000013; cache_compressed = 1'b0;
      repeat (6) cycle();
      chk("full_req_pc", req_pc, 32'h10);
      chk("full_req_valid", {31'b0, req_valid}, 32'h0);
      ready_in = 1'b1;
      cycle();
      chk("after_deq_req_pc", req_pc, 32'h10);
      chk("after_deq_req_valid", {31'b0, req_valid}, 32'h1);
      cycle();
      chk("after_enq_req_pc", req_pc, 32'h14);
      cache_valid = 1'b0;
      repeat (5) cycle();

      // mixed compressed/uncompressed run from 0x100
      ready_in = 1'b0;
      valid_from_decoder = 1'b1; pc_from_decoder = 32'h100;
      cycle();
      valid_from_decoder = 1'b0;
      cache_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cache_compressed = (i % 2 == 0);
         cache_inst = 32'h1000 + i;
         cycle();
      end
      cache_valid = 1'b0;
      chk("rvc_head_pc", pc_out, 32'h100);
      chk("rvc_req_pc", req_pc, 32'h10c);
      ready_in = 1'b1;
      repeat (5) cycle();

      // redirect priority with three entries queued
      ready_in = 1'b0; cache_valid = 1'b1; cache_compressed = 1'b0; cache_inst = 32'h00000033;
      repeat (3) cycle();
      cache_valid = 1'b0;
      valid_from_rob = 1'b1; pc_from_rob = 32'h2000;
      valid_from_decoder = 1'b1; pc_from_decoder = 32'h3000;
      ready_in = 1'b1;
      cycle();
      valid_from_rob = 1'b0; valid_from_decoder = 1'b0;
      chk("flush_valid_out", {31'b0, valid_out}, 32'h0);
      chk("flush_req_pc", req_pc, 32'h2000);
      ready_in = 1'b0;

      // predictor training and saturation at 0x40
      branch_updates(2, 1'b1);
      fetch_at_40(1'b1, 1'b0, 1'b0);
      branch_updates(4, 1'b0);
      fetch_at_40(1'b0, 1'b0, 1'b0);
      branch_updates(2, 1'b1);
      fetch_at_40(1'b1, 1'b1, 1'b0);
      fetch_at_40(1'b0, 1'b0, 1'b0);
      branch_updates(10, 1'b1);
      fetch_at_40(1'b1, 1'b0, 1'b0);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/fetch_predict_unit.md
FETCH_PREDICT_UNIT -- requirements
Module: fetch_predict_unit

Interface
REQ-001 Parameter BHT_IDX_W, default 6, log2 of branch-history-table entries.
REQ-002 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-004 clk_in  input  1  sole clock; all state on rising edge.
REQ-005 rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 pc_from_rob / valid_from_rob  input  32/1  mispredict redirect.
REQ-007 pc_from_decoder / valid_from_decoder  input  32/1  decode-stage redirect.
REQ-008 pc_of_branch / branch_taken / branch_record_valid  input  32/1/1  resolved-branch update.
REQ-009 req_pc / req_valid  output  32/1  icache lookup address and strobe.
REQ-010 cache_inst / cache_compressed / cache_valid  input  32/1/1  same-cycle icache hit response for req_pc.
REQ-011 inst_out / pc_out  output  32/32  queue-head instruction and its address.
REQ-012 compressed_out / pred_taken_out  output  1/1  queue-head RVC flag and predicted direction.
REQ-013 valid_out / ready_in  output/input  1/1  decoder handshake; transfer when both high.

Function
REQ-014 Internal fetch_pc register; req_pc = fetch_pc, combinational.
REQ-015 req_valid = queue not full AND no redirect this cycle.
REQ-016 Enqueue when req_valid AND cache_valid: entry {cache_inst, fetch_pc, cache_compressed, prediction}; fetch_pc += 2 if compressed, else += 4 (mod 2^32).
REQ-017 No enqueue: fetch_pc holds.
REQ-018 Full test uses pre-edge count; enqueue blocked at count == FQ_DEPTH even with simultaneous dequeue.
REQ-019 Dequeue on valid_out AND ready_in; enqueue and dequeue in the same cycle leave count unchanged.
REQ-020 valid_out = count != 0; head outputs driven from queue storage; inst_out, pc_out, compressed_out and pred_taken_out are don't-care when valid_out is low.
REQ-021 Pointers wrap modulo FQ_DEPTH; count width log2(FQ_DEPTH)+1.
REQ-022 valid_from_rob: next edge empties queue, fetch_pc <= pc_from_rob, no enqueue or dequeue.
REQ-023 valid_from_decoder without valid_from_rob: same as REQ-022 using pc_from_decoder.
REQ-024 valid_from_rob takes priority over valid_from_decoder.
REQ-025 Branch predictor: 2^BHT_IDX_W 2-bit saturating counters indexed by pc[BHT_IDX_W:1]; prediction = counter[1].
REQ-026 On branch_record_valid, counter at pc_of_branch index increments if branch_taken, else decrements; saturates at 3 and 0.
REQ-027 Update is independent of redirects and queue state.
REQ-028 Lookup and update to the same index in one cycle: lookup returns pre-update value.
REQ-029 Direction only; target is computed downstream and returned via the decoder redirect.

Reset
REQ-030 rst_n_in low asynchronously forces: fetch_pc = RESET_PC, queue empty, valid_out = 0, all BHT counters = 2'b01.
REQ-031 Redirect and update inputs are ignored while reset is asserted.
REQ-032 First req_valid follows the first rising edge after release.

Configuration
REQ-033 Macro FETCH_BHT_EN defined: BHT implemented per REQ-025 to REQ-028.
REQ-034 FETCH_BHT_EN undefined: no BHT storage, pred_taken_out always 0 for valid entries, branch_record_valid ignored; all other behaviour identical.

Verification
REQ-035 Reset release, cache_valid = 1, inst 32'h00000013 uncompressed, ready_in = 0 -> req_pc 0,4,8,12, then req_valid = 0 and fetch_pc holds at 16 with queue full (FQ_DEPTH = 4).
REQ-036 Alternating compressed and uncompressed hits from 0x100 -> pc_out sequence 0x100, 0x102, 0x106, 0x108.
REQ-037 Queue holds 3 entries, valid_from_rob = 1 with 0x2000 and valid_from_decoder = 1 with 0x3000 in the same cycle -> valid_out = 0 next cycle, then next req_pc = 0x2000.
REQ-038 Two updates taken at 0x40 -> entry 0x40 pred_taken_out = 1; three updates not-taken -> 0, with counter saturated at 0.
REQ-039 FETCH_BHT_EN undefined, ten taken updates at 0x40 -> pred_taken_out stays 0.
REQ-040 Queue full, ready_in = 1, cache_valid = 1 -> one dequeue, no enqueue that cycle, enqueue on the following cycle.
